// File: rtl/mgpu_pkg.sv
// rtl/mgpu_pkg.sv - shared MiniGPU encodings for core pipeline and LSU states
// Also provides the width helper for the optional LSU timeout counter.
package mgpu_pkg;

  typedef enum logic [2:0] {
    CORE_FETCH   = 3'd0,
    CORE_DECODE  = 3'd1,
    CORE_REQUEST = 3'd2,
    CORE_WAIT    = 3'd3,
    CORE_EXECUTE = 3'd4,
    CORE_UPDATE  = 3'd5,
    CORE_DONE    = 3'd6,
    CORE_IDLE    = 3'd7
  } core_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_REQUEST = 2'd1,
    LSU_WAIT    = 2'd2,
    LSU_DONE    = 2'd3
  } lsu_state_e;

  // Wide enough to hold the terminal count itself.
  function automatic int timeout_ctr_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/lsu_param_if.sv
// rtl/lsu_param_if.sv - per-thread memory channel between the LSU and the memory controller
// master is the LSU side; slave is the memory controller side.
interface lsu_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) ();

  logic                  mem_read_valid;
  logic [ADDR_WIDTH-1:0] mem_read_address;
  logic                  mem_read_ready;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_write_valid;
  logic [ADDR_WIDTH-1:0] mem_write_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/lsu_param_timeout_ctr.sv
// rtl/lsu_param_timeout_ctr.sv - WAIT-state cycle counter for the LSU (used under LSU_TIMEOUT_EN)
// expire pulses on the LIMIT-th consecutive counted cycle.
module lsu_timeout_ctr
  import mgpu_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic incr,
  output logic expire
);

  localparam int CW = timeout_ctr_width(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (incr) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = incr && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/lsu_param.sv
// rtl/lsu_param.sv - parametrised per-thread load/store unit for the MiniGPU core
// Define LSU_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES and raise lsu_err.
module lsu_param
  import mgpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            core_state,
  input  logic                  decoded_mem_read_enable,
  input  logic                  decoded_mem_write_enable,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  lsu_param_if.master           mem,
  output logic [DATA_WIDTH-1:0] lsu_out,
  output logic [1:0]            lsu_state,
  output logic                  lsu_err
);

  if (ADDR_WIDTH > DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("lsu_param: ADDR_WIDTH must not exceed DATA_WIDTH and TIMEOUT_CYCLES must be >= 1");
  end

  lsu_state_e            state_q, state_d;
  logic                  op_read_q, op_read_d;
  logic                  op_write_q, op_write_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  err_q, err_d;
  logic                  op_read, op_write;
  logic                  tmr_expire;

  // Read wins when the decoder flags both.
  assign op_read  = decoded_mem_read_enable;
  assign op_write = decoded_mem_write_enable & ~decoded_mem_read_enable;

`ifdef LSU_TIMEOUT_EN
  logic wait_ready;

  assign wait_ready = op_read_q ? mem.mem_read_ready : mem.mem_write_ready;

  lsu_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (state_q == LSU_REQUEST),
    .incr   ((state_q == LSU_WAIT) && !wait_ready),
    .expire (tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_read_d  = op_read_q;
    op_write_d = op_write_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
    err_d      = err_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (enable && (op_read || op_write) && (core_state == CORE_REQUEST)) begin
          state_d    = LSU_REQUEST;
          op_read_d  = op_read;
          op_write_d = op_write;
          err_d      = 1'b0;
        end
      end
      LSU_REQUEST: begin
        state_d = LSU_WAIT;
        if (op_read_q) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = rs[ADDR_WIDTH-1:0];
        end else begin
          wr_valid_d = 1'b1;
          wr_addr_d  = rs[ADDR_WIDTH-1:0];
          wr_data_d  = rt;
        end
      end
      LSU_WAIT: begin
        // A ready in the expiry cycle completes normally.
        if (op_read_q && mem.mem_read_ready) begin
          out_d      = mem.mem_read_data;
          rd_valid_d = 1'b0;
          state_d    = LSU_DONE;
        end else if (op_write_q && mem.mem_write_ready) begin
          wr_valid_d = 1'b0;
          state_d    = LSU_DONE;
        end else if (tmr_expire) begin
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          err_d      = 1'b1;
          state_d    = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (core_state == CORE_UPDATE) begin
          state_d    = LSU_IDLE;
          op_read_d  = 1'b0;
          op_write_d = 1'b0;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LSU_IDLE;
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_read_q  <= op_read_d;
      op_write_q <= op_write_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  assign mem.mem_read_valid    = rd_valid_q;
  assign mem.mem_read_address  = rd_addr_q;
  assign mem.mem_write_valid   = wr_valid_q;
  assign mem.mem_write_address = wr_addr_q;
  assign mem.mem_write_data    = wr_data_q;
  assign lsu_out               = out_q;
  assign lsu_state             = state_q;
  assign lsu_err               = err_q;

endmodule

// File: tb/tb_lsu_param.sv
// tb/tb_lsu_param.sv - directed and randomized checks of lsu_param against a transaction-level model
// Timeout cases are exercised when LSU_TIMEOUT_EN is defined.
module tb_lsu_param;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic [7:0] lsu_out;
  logic [1:0] lsu_state;
  logic       lsu_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_out;

  lsu_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) mem_if ();

  lsu_param #(
    .DATA_WIDTH     (8),
    .ADDR_WIDTH     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                      (clk),
    .reset                    (rst_n),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem                      (mem_if),
    .lsu_out                  (lsu_out),
    .lsu_state                (lsu_state),
    .lsu_err                  (lsu_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_rvalid"}, mem_if.mem_read_valid, 0);
    check({tag, "_wvalid"}, mem_if.mem_write_valid, 0);
  endtask

  // One full transaction; expectations come from the handshake rules only.
  task automatic run_op(input bit en, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] rdata, input int delay,
                        input string tag);
    bit go, is_rd;
    go    = en && (rd || wr);
    is_rd = rd;
    enable = en; rd_en = rd; wr_en = wr;
    rs = ~a; rt = ~d;
    core_state = 3'd2;
    mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0;
    mem_if.mem_read_data = ~rdata;
    tick();
    check({tag, "_req_state"}, lsu_state, go ? 1 : 0);
    if (!go) begin
      check_idle_bus({tag, "_noreq"});
      tick();
      check({tag, "_still_idle"}, lsu_state, 0);
      check_idle_bus({tag, "_noreq2"});
      core_state = 3'd0; rd_en = 1'b0; wr_en = 1'b0;
      return;
    end
    enable = 1'($urandom_range(0, 1));
    core_state = 3'd3; rs = a; rt = d;
    tick();
    check({tag, "_wait_state"}, lsu_state, 2);
    check({tag, "_rvalid_on"}, mem_if.mem_read_valid, is_rd ? 1 : 0);
    check({tag, "_wvalid_on"}, mem_if.mem_write_valid, is_rd ? 0 : 1);
    rs = 8'($urandom); rt = 8'($urandom);
    if (is_rd) mem_if.mem_write_ready = 1'b1;
    else       mem_if.mem_read_ready  = 1'b1;
    for (int i = 0; i <= delay; i++) begin
      if (i > 0) tick();
      check({tag, "_hold_state"}, lsu_state, 2);
      if (is_rd) begin
        check({tag, "_hold_rvalid"}, mem_if.mem_read_valid, 1);
        check({tag, "_hold_raddr"}, mem_if.mem_read_address, a);
      end else begin
        check({tag, "_hold_wvalid"}, mem_if.mem_write_valid, 1);
        check({tag, "_hold_waddr"}, mem_if.mem_write_address, a);
        check({tag, "_hold_wdata"}, mem_if.mem_write_data, d);
      end
    end
    mem_if.mem_read_data = rdata;
    if (is_rd) mem_if.mem_read_ready  = 1'b1;
    else       mem_if.mem_write_ready = 1'b1;
    tick();
    if (is_rd) exp_out = rdata;
    check({tag, "_done_state"}, lsu_state, 3);
    check_idle_bus({tag, "_done"});
    check({tag, "_lsu_out"}, lsu_out, exp_out);
    check({tag, "_err"}, lsu_err, 0);
    mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0;
    core_state = 3'd4;
    tick();
    check({tag, "_done_hold"}, lsu_state, 3);
    core_state = 3'd5;
    tick();
    check({tag, "_back_idle"}, lsu_state, 0);
    check({tag, "_out_kept"}, lsu_out, exp_out);
    core_state = 3'd0; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic start_read(input logic [7:0] a, input string tag);
    enable = 1'b1; rd_en = 1'b1; wr_en = 1'b0; rs = a; core_state = 3'd2;
    mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0;
    tick();
    check({tag, "_req"}, lsu_state, 1);
    check({tag, "_err_clr"}, lsu_err, 0);
    core_state = 3'd3;
    tick();
    check({tag, "_wait"}, lsu_state, 2);
    check({tag, "_rvalid"}, mem_if.mem_read_valid, 1);
  endtask

  task automatic finish_op();
    mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0;
    core_state = 3'd5;
    tick();
    core_state = 3'd0; rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; core_state = 3'd0; rd_en = 1'b0; wr_en = 1'b0;
    rs = 8'h00; rt = 8'h00; exp_out = 8'h00;
    mem_if.mem_read_ready = 1'b0; mem_if.mem_write_ready = 1'b0; mem_if.mem_read_data = 8'h00;
    tick();
    tick();
    check("rst_state", lsu_state, 0);
    check("rst_out", lsu_out, 0);
    check("rst_err", lsu_err, 0);
    check("rst_raddr", mem_if.mem_read_address, 0);
    check("rst_waddr", mem_if.mem_write_address, 0);
    check("rst_wdata", mem_if.mem_write_data, 0);
    check_idle_bus("rst");
    rst_n = 1'b1;
    tick();

    run_op(1'b1, 1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 0, "ld_imm");
    run_op(1'b1, 1'b0, 1'b1, 8'h10, 8'hEE, 8'h99, 5, "st_dly5");
    run_op(1'b1, 1'b1, 1'b1, 8'h04, 8'h77, 8'hA5, 2, "both_en");
    run_op(1'b0, 1'b1, 1'b0, 8'h31, 8'h00, 8'h12, 0, "disabled");

`ifdef LSU_TIMEOUT_EN
    start_read(8'h61, "tmo");
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      check("tmo_pending", lsu_state, 2);
    end
    tick();
    check("tmo_done", lsu_state, 3);
    check("tmo_err", lsu_err, 1);
    check("tmo_rvalid", mem_if.mem_read_valid, 0);
    check("tmo_out", lsu_out, exp_out);
    finish_op();
    start_read(8'h62, "tmo_race");
    for (int i = 0; i < TMO - 1; i++) tick();
    mem_if.mem_read_ready = 1'b1; mem_if.mem_read_data = 8'h3C;
    tick();
    exp_out = 8'h3C;
    check("race_done", lsu_state, 3);
    check("race_err", lsu_err, 0);
    check("race_out", lsu_out, exp_out);
    finish_op();
`else
    start_read(8'h61, "nowait");
    for (int i = 0; i < 3 * TMO; i++) tick();
    check("nowait_state", lsu_state, 2);
    check("nowait_rvalid", mem_if.mem_read_valid, 1);
    check("nowait_err", lsu_err, 0);
    mem_if.mem_read_ready = 1'b1; mem_if.mem_read_data = 8'hC3;
    tick();
    exp_out = 8'hC3;
    check("nowait_done", lsu_state, 3);
    check("nowait_out", lsu_out, exp_out);
    finish_op();
`endif

    for (int n = 0; n < 24; n++) begin
      run_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)), "rand");
    end

    run_op(1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 8'hB7, 0, "pre_rst");
    start_read(8'h33, "rst_mid");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp_out = 8'h00;
    check("amid_state", lsu_state, 0);
    check("amid_rvalid", mem_if.mem_read_valid, 0);
    check("amid_out", lsu_out, exp_out);
    check("amid_raddr", mem_if.mem_read_address, 0);
    #1;
    rst_n = 1'b1; rd_en = 1'b0; core_state = 3'd0;
    tick();
    check("after_rst_state", lsu_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
